// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer
//   BCD MM:SS down-counter for the alarm path. Loaded with a minutes/seconds
//   value, decrements once per 1 Hz tick while running, and rings at 00:00
//   for RING_TICKS ticks (or until acknowledged with start).
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   tick      1-cycle 1 Hz strobe
//   load      capture min_in/sec_in (IDLE or PAUSE only)
//   min_in    BCD minutes 00..99
//   sec_in    BCD seconds 00..59
//   start     begin/resume countdown, or acknowledge ring
//   pause     suspend countdown
//   clear     abort, zero counts, return to IDLE
//   min_out   current minutes (BCD, registered)
//   sec_out   current seconds (BCD, registered)
//   running   high in RUN
//   ring      high in RING
//   load_err  1-cycle pulse when a load carries invalid BCD
module bcd_countdown_timer #(
    parameter int RING_TICKS = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       load,
    input  logic [7:0] min_in,
    input  logic [7:0] sec_in,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    output logic [7:0] min_out,
    output logic [7:0] sec_out,
    output logic       running,
    output logic       ring,
    output logic       load_err
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, RING} state_t;

    state_t     state, state_nx;
    logic [7:0] min_nx, sec_nx;
    logic [7:0] rcnt, rcnt_nx;
    logic       err_nx;

    logic       in_valid;
    logic       cnt_zero;
    logic       idle_or_pause;
    logic [7:0] dec_min, dec_sec;
    logic       ring_done;

    assign in_valid      = (min_in[7:4] <= 4'd9) && (min_in[3:0] <= 4'd9) &&
                           (sec_in[7:4] <= 4'd5) && (sec_in[3:0] <= 4'd9);
    assign cnt_zero      = (min_out == 8'h00) && (sec_out == 8'h00);
    assign idle_or_pause = (state == IDLE) || (state == PAUSE);
    assign ring_done     = tick && ((rcnt + 8'd1) == 8'(RING_TICKS));

    // One-second BCD decrement with borrow chain sec units -> sec tens -> minutes.
    // Only used when the count is non-zero, so it never wraps below 00:00.
    always_comb begin
        dec_min = min_out;
        dec_sec = sec_out;
        if (sec_out[3:0] != 4'd0) begin
            dec_sec[3:0] = sec_out[3:0] - 4'd1;
        end else if (sec_out[7:4] != 4'd0) begin
            dec_sec = {sec_out[7:4] - 4'd1, 4'd9};
        end else begin
            dec_sec = 8'h59;
            if (min_out[3:0] != 4'd0)
                dec_min[3:0] = min_out[3:0] - 4'd1;
            else
                dec_min = {min_out[7:4] - 4'd1, 4'd9};
        end
    end

    // State register; running/ring are registered alongside it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            running  <= 1'b0;
            ring     <= 1'b0;
            min_out  <= 8'h00;
            sec_out  <= 8'h00;
            rcnt     <= 8'h00;
            load_err <= 1'b0;
        end else begin
            state    <= state_nx;
            running  <= (state_nx == RUN);
            ring     <= (state_nx == RING);
            min_out  <= min_nx;
            sec_out  <= sec_nx;
            rcnt     <= rcnt_nx;
            load_err <= err_nx;
        end
    end

    // Next-state logic. A load in IDLE/PAUSE consumes the cycle, so start is
    // not taken with it; load in RUN/RING falls through to lower priorities.
    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE, PAUSE: if (!load && start && !cnt_zero) state_nx = RUN;
                RUN: begin
                    if (pause)
                        state_nx = PAUSE;
                    else if (tick && (cnt_zero || (dec_min == 8'h00 && dec_sec == 8'h00)))
                        state_nx = RING;
                end
                RING: begin
                    if (start || ring_done) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Datapath next values. The ring counter is held at zero outside RING,
    // which gives the clear-on-entry behaviour for free.
    always_comb begin
        min_nx  = min_out;
        sec_nx  = sec_out;
        rcnt_nx = 8'h00;
        err_nx  = 1'b0;
        if (clear) begin
            min_nx = 8'h00;
            sec_nx = 8'h00;
        end else if (load && idle_or_pause) begin
            if (in_valid) begin
                min_nx = min_in;
                sec_nx = sec_in;
            end else begin
                err_nx = 1'b1;
            end
        end else if (state == RUN) begin
            if (!pause && tick && !cnt_zero) begin
                min_nx = dec_min;
                sec_nx = dec_sec;
            end
        end else if (state == RING) begin
            if (!start && tick) rcnt_nx = rcnt + 8'd1;
            else if (!start)    rcnt_nx = rcnt;
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
module tb_bcd_countdown_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick, load, start, pause, clear;
    logic [7:0] min_in, sec_in;
    logic [7:0] min_out, sec_out;
    logic       running, ring, load_err;

    int vec = 0;
    int err = 0;

    bcd_countdown_timer #(.RING_TICKS(30)) dut (
        .clk(clk), .rst(rst), .tick(tick), .load(load),
        .min_in(min_in), .sec_in(sec_in), .start(start), .pause(pause),
        .clear(clear), .min_out(min_out), .sec_out(sec_out),
        .running(running), .ring(ring), .load_err(load_err)
    );

    always #5 clk = ~clk;

    // Observed output bundle: {min, sec, running, ring, load_err}
    wire [18:0] obs = {min_out, sec_out, running, ring, load_err};

    // Advance one edge, then drop all single-cycle strobes; sampled 1 ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        tick = 0; load = 0; start = 0; pause = 0; clear = 0;
    endtask

    task automatic do_load(input logic [7:0] m, input logic [7:0] s);
        load = 1; min_in = m; sec_in = s;
        cyc();
    endtask

    task automatic test_reset();
        logic [18:0] exp;
        rst = 1; tick = 0; load = 0; start = 0; pause = 0; clear = 0;
        min_in = 0; sec_in = 0;
        cyc(); cyc();
        exp = {8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        vec++; if (obs !== exp) begin err++; $display("FAIL reset_state: got %h want %h", obs, exp); end
        rst = 0;
        cyc();
        do_load(8'h05, 8'h30);
        start = 1; cyc();
        exp = {8'h05, 8'h30, 1'b1, 1'b0, 1'b0};
        vec++; if (obs !== exp) begin err++; $display("FAIL run_0530: got %h want %h", obs, exp); end
        #2 rst = 1;
        #1;
        exp = {8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        vec++; if (obs !== exp) begin err++; $display("FAIL async_reset: got %h want %h", obs, exp); end
        cyc();
        rst = 0;
        cyc();
    endtask

    task automatic test_countdown();
        logic [18:0] exp;
        logic [7:0]  secs [5];
        secs = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
        do_load(8'h01, 8'h05);
        start = 1; cyc();
        exp = {8'h01, 8'h05, 1'b1, 1'b0, 1'b0};
        vec++; if (obs !== exp) begin err++; $display("FAIL start_0105: got %h want %h", obs, exp); end
        for (int i = 0; i < 5; i++) begin
            tick = 1; cyc();
            exp = {8'h01, secs[i], 1'b1, 1'b0, 1'b0};
            vec++; if (obs !== exp) begin err++; $display("FAIL countdown_tick%0d: got %h want %h", i, obs, exp); end
            cyc();
        end
        tick = 1; cyc();
        exp = {8'h00, 8'h59, 1'b1, 1'b0, 1'b0};
        vec++; if (obs !== exp) begin err++; $display("FAIL borrow_min: got %h want %h", obs, exp); end
        clear = 1; cyc();
        exp = {8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        vec++; if (obs !== exp) begin err++; $display("FAIL clear_run: got %h want %h", obs, exp); end
    endtask

    task automatic test_ring();
        logic [18:0] exp;
        do_load(8'h00, 8'h02);
        start = 1; cyc();
        tick = 1; cyc();
        exp = {8'h00, 8'h01, 1'b1, 1'b0, 1'b0};
        vec++; if (obs !== exp) begin err++; $display("FAIL ring_pre: got %h want %h", obs, exp); end
        tick = 1; cyc();
        exp = {8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
        vec++; if (obs !== exp) begin err++; $display("FAIL ring_enter: got %h want %h", obs, exp); end
        for (int i = 0; i < 29; i++) begin
            tick = 1; cyc();
            cyc();
        end
        exp = {8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
        vec++; if (obs !== exp) begin err++; $display("FAIL ring_29ticks: got %h want %h", obs, exp); end
        tick = 1; cyc();
        exp = {8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        vec++; if (obs !== exp) begin err++; $display("FAIL ring_timeout: got %h want %h", obs, exp); end
        // Acknowledge path
        do_load(8'h00, 8'h02);
        start = 1; cyc();
        tick = 1; cyc();
        tick = 1; cyc();
        exp = {8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
        vec++; if (obs !== exp) begin err++; $display("FAIL ring_enter2: got %h want %h", obs, exp); end
        tick = 1; cyc();
        start = 1; cyc();
        exp = {8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        vec++; if (obs !== exp) begin err++; $display("FAIL ring_ack: got %h want %h", obs, exp); end
        // Ring counter must restart from zero: a fresh ring still lasts 30 ticks
        do_load(8'h00, 8'h01);
        start = 1; cyc();
        tick = 1; cyc();
        for (int i = 0; i < 29; i++) begin
            tick = 1; cyc();
        end
        exp = {8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
        vec++; if (obs !== exp) begin err++; $display("FAIL ring_restart29: got %h want %h", obs, exp); end
        tick = 1; cyc();
        exp = {8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        vec++; if (obs !== exp) begin err++; $display("FAIL ring_restart30: got %h want %h", obs, exp); end
    endtask

    task automatic test_load_err();
        logic [18:0] exp;
        do_load(8'h1A, 8'h00);
        exp = {8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
        vec++; if (obs !== exp) begin err++; $display("FAIL load_err_min: got %h want %h", obs, exp); end
        cyc();
        exp = {8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        vec++; if (obs !== exp) begin err++; $display("FAIL load_err_pulse: got %h want %h", obs, exp); end
        do_load(8'h00, 8'h60);
        exp = {8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
        vec++; if (obs !== exp) begin err++; $display("FAIL load_err_sec: got %h want %h", obs, exp); end
        start = 1; cyc();
        exp = {8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        vec++; if (obs !== exp) begin err++; $display("FAIL start_zero: got %h want %h", obs, exp); end
    endtask

    task automatic test_pause();
        logic [18:0] exp;
        do_load(8'h00, 8'h10);
        start = 1; cyc();
        tick = 1; pause = 1; cyc();
        exp = {8'h00, 8'h10, 1'b0, 1'b0, 1'b0};
        vec++; if (obs !== exp) begin err++; $display("FAIL pause_tick: got %h want %h", obs, exp); end
        tick = 1; cyc();
        vec++; if (obs !== exp) begin err++; $display("FAIL tick_in_pause: got %h want %h", obs, exp); end
        do_load(8'h02, 8'h00);
        exp = {8'h02, 8'h00, 1'b0, 1'b0, 1'b0};
        vec++; if (obs !== exp) begin err++; $display("FAIL load_pause: got %h want %h", obs, exp); end
        start = 1; cyc();
        exp = {8'h02, 8'h00, 1'b1, 1'b0, 1'b0};
        vec++; if (obs !== exp) begin err++; $display("FAIL resume: got %h want %h", obs, exp); end
        do_load(8'h03, 8'h00);
        vec++; if (obs !== exp) begin err++; $display("FAIL load_in_run: got %h want %h", obs, exp); end
        start = 1; pause = 1; cyc();
        exp = {8'h02, 8'h00, 1'b0, 1'b0, 1'b0};
        vec++; if (obs !== exp) begin err++; $display("FAIL start_pause_run: got %h want %h", obs, exp); end
        clear = 1; load = 1; min_in = 8'h03; sec_in = 8'h00; cyc();
        exp = {8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        vec++; if (obs !== exp) begin err++; $display("FAIL clear_over_load: got %h want %h", obs, exp); end
    endtask

    task automatic test_boundary();
        logic [18:0] exp;
        do_load(8'h99, 8'h59);
        start = 1; cyc();
        tick = 1; cyc();
        exp = {8'h99, 8'h58, 1'b1, 1'b0, 1'b0};
        vec++; if (obs !== exp) begin err++; $display("FAIL max_tick: got %h want %h", obs, exp); end
        clear = 1; cyc();
        do_load(8'h10, 8'h00);
        start = 1; cyc();
        tick = 1; cyc();
        exp = {8'h09, 8'h59, 1'b1, 1'b0, 1'b0};
        vec++; if (obs !== exp) begin err++; $display("FAIL borrow_1000: got %h want %h", obs, exp); end
        clear = 1; cyc();
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_ring();
        test_load_err();
        test_pause();
        test_boundary();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
